ramp_phase_sequencer: RTL and testbench
=======================================

Name: ramp_phase_sequencer

Overview:
- Upstream companion of the shared sequential divider in the voice path.
- Tracks the phase position of a note within its period, one step per audio sample tick.
- Per tick, presents dividend = phase position and divider = note period, pulses the divider enable, waits a fixed latency, then captures the 8-bit quotient as the sawtooth sample.
- Drives the divider's en/dividend/divider inputs and consumes its quotient output.

Parameters:
- DIV_LATENCY, 20, cycles from the div_en pulse to quotient capture. Must be ≥ the divider's worst-case en-to-quotient-valid latency. Legal range 2..255.

Ports:
- clk  input  1  system clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- sample_tick  input  1  one-cycle pulse at audio sample rate
- note_period  input  16  samples per waveform cycle; 0 = silent
- quotient  input  8  result from divider
- div_en  output  1  one-cycle start pulse to divider
- dividend  output  16  phase position to divider
- divider  output  16  latched period to divider
- sample_out  output  8  current waveform sample
- sample_valid  output  1  one-cycle pulse when sample_out updates
- busy  output  1  high whenever state != IDLE
- overrun  output  1  one-cycle pulse when a tick is dropped

Behaviour:
- Reset (async, rst=1): state=IDLE, pos=0, dividend=0, divider=0, sample_out=0, div_en=0, sample_valid=0, overrun=0, wait counter=0. A reset mid-operation abandons the division; no capture occurs.
- States: IDLE, LAUNCH, WAIT, CAPTURE.
- IDLE, sample_tick=1, note_period=0:
  - pos<=0, sample_out<=0, sample_valid=1 next cycle.
  - Stays IDLE; no div_en.
- IDLE, sample_tick=1, note_period≠0:
  - divider<=note_period.
  - dividend<=pos if pos<note_period, else 0; pos is updated to the same value.
  - Goes to LAUNCH.
- LAUNCH: div_en=1 for exactly this one cycle; wait counter<=DIV_LATENCY-1; goes to WAIT.
- WAIT: counter decrements each cycle; when counter==0, goes to CAPTURE.
- CAPTURE:
  - sample_out<=quotient; sample_valid=1 in the following cycle (registered pulse).
  - pos<=0 if dividend+1 ≥ divider, else dividend+1.
  - Goes to IDLE.
- Tick-to-sample_valid latency: DIV_LATENCY+3 cycles (IDLE→LAUNCH 1, LAUNCH→WAIT 1, WAIT DIV_LATENCY, CAPTURE→valid 1).
- dividend and divider are held stable from LAUNCH through CAPTURE. They change only on an accepted tick.
- Ticks and overrun:
  - A sample_tick while busy=1 is dropped; overrun pulses 1 cycle later.
  - pos does not advance for dropped ticks.
  - A tick coinciding with the CAPTURE cycle is dropped (busy still 1).
- Period changes:
  - note_period is sampled only on accepted ticks.
  - A changed period takes effect at the next accepted tick.
  - A shrink that leaves pos ≥ new period wraps pos to 0 before launch.
- Arithmetic: pos+1 is computed at 17 bits, so there is no overflow at pos=16'hFFFE with period=16'hFFFF. The wrap-to-0 comparison uses the 17-bit sum.
- busy and div_en are registered outputs; no combinational path from inputs to outputs.

Test Plan:
- Reset then idle: assert rst mid-WAIT → all outputs 0 within same cycle (async); after release, state IDLE, no div_en until next tick.
- Ramp with stub divider (stub returns quotient = dividend[7:0]), note_period=4, DIV_LATENCY=20:
  - Ticks every 40 cycles.
  - dividend sequence 0,1,2,3,0,1.
  - sample_valid exactly 23 cycles after each tick.
  - sample_out 0,1,2,3,0,1.
  - div_en exactly one cycle per tick.
- Silent note: note_period=0, tick → no div_en; sample_valid next cycle with sample_out=0; pos stays 0.
- Overrun: note_period=8, second tick 5 cycles after first → overrun pulse 1 cycle after second tick; only one sample_valid; next accepted tick uses dividend=1.
- Period shrink: period=10, run to pos=7, change to 5, tick → dividend=0, divider=5; following accepted tick → dividend=1.
- Wide boundary: period=16'hFFFF, force pos to 16'hFFFE via ticks/stub run → after capture, next dividend=0 (wrap), no X/overflow.

Source files
------------

// File: rtl/ramp_phase_sequencer.sv
// Sawtooth phase sequencer: advances a phase position once per sample tick and uses an
// external sequential divider (pos / period) to turn that position into an 8-bit ramp sample.
module ramp_phase_sequencer #(
   parameter int DIV_LATENCY = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sample_tick,
   input  logic [15:0] note_period,
   input  logic [7:0]  quotient,
   output logic        div_en,
   output logic [15:0] dividend,
   output logic [15:0] divider,
   output logic [7:0]  sample_out,
   output logic        sample_valid,
   output logic        busy,
   output logic        overrun
);

   localparam logic [7:0] WAIT_INIT = 8'(DIV_LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LAUNCH  = 2'd1,
      WAIT    = 2'd2,
      CAPTURE = 2'd3
   } state_t;

   state_t      state;
   state_t      next_state;
   logic [15:0] pos;
   logic [7:0]  wait_cnt;

   logic        tick_silent;
   logic        tick_launch;
   logic [15:0] pos_start;
   logic [16:0] pos_inc;
   logic        pos_wrap;

   logic        div_en_next;
   logic        busy_next;
   logic        overrun_next;
   logic        valid_next;

   assign tick_silent = sample_tick && (note_period == 16'd0);
   assign tick_launch = sample_tick && (note_period != 16'd0);
   // A shrunken period can leave pos beyond the new range, so restart the ramp there.
   assign pos_start   = (pos < note_period) ? pos : 16'd0;
   // 17-bit increment keeps pos=16'hFFFE with period 16'hFFFF from overflowing.
   assign pos_inc     = {1'b0, dividend} + 17'd1;
   assign pos_wrap    = (pos_inc >= {1'b0, divider});

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (tick_launch) begin
               next_state = LAUNCH;
            end else begin
               next_state = IDLE;
            end
         end
         LAUNCH: next_state = WAIT;
         WAIT: begin
            if (wait_cnt == 8'd0) begin
               next_state = CAPTURE;
            end else begin
               next_state = WAIT;
            end
         end
         CAPTURE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Output decode: next values of the registered control outputs.
   always_comb begin
      div_en_next  = 1'b0;
      valid_next   = 1'b0;
      overrun_next = 1'b0;
      busy_next    = (next_state != IDLE);
      case (state)
         IDLE: begin
            div_en_next = tick_launch;
            valid_next  = tick_silent;
         end
         LAUNCH: begin
            overrun_next = sample_tick;
         end
         WAIT: begin
            overrun_next = sample_tick;
         end
         CAPTURE: begin
            valid_next   = 1'b1;
            overrun_next = sample_tick;
         end
         default: begin
            div_en_next = 1'b0;
         end
      endcase
   end

   // Registered control outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_en       <= 1'b0;
         busy         <= 1'b0;
         overrun      <= 1'b0;
         sample_valid <= 1'b0;
      end else begin
         div_en       <= div_en_next;
         busy         <= busy_next;
         overrun      <= overrun_next;
         sample_valid <= valid_next;
      end
   end

   // Datapath: phase position, divider operands, latency counter and captured sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos        <= 16'd0;
         dividend   <= 16'd0;
         divider    <= 16'd0;
         sample_out <= 8'd0;
         wait_cnt   <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (tick_silent) begin
                  pos        <= 16'd0;
                  sample_out <= 8'd0;
               end else if (tick_launch) begin
                  divider  <= note_period;
                  dividend <= pos_start;
                  pos      <= pos_start;
               end
            end
            LAUNCH: begin
               wait_cnt <= WAIT_INIT;
            end
            WAIT: begin
               if (wait_cnt != 8'd0) begin
                  wait_cnt <= wait_cnt - 8'd1;
               end
            end
            CAPTURE: begin
               sample_out <= quotient;
               pos        <= pos_wrap ? 16'd0 : pos_inc[15:0];
            end
            default: begin
               wait_cnt <= 8'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ramp_phase_sequencer.sv
// Self-checking bench for ramp_phase_sequencer: timeline-based reference model checked every
// cycle, directed scenarios with literal expectations, then randomized ticks and period changes.
module tb_ramp_phase_sequencer;
   localparam int L = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic        sample_tick;
   logic [15:0] note_period;
   logic [7:0]  quotient = 8'd0;
   logic        div_en;
   logic [15:0] dividend;
   logic [15:0] divider;
   logic [7:0]  sample_out;
   logic        sample_valid;
   logic        busy;
   logic        overrun;

   int tests = 0;
   int fails = 0;

   // reference model: absolute edge numbers of the in-flight request
   int       e_cnt;
   int       a_edge;
   int       m_pos, m_dvd, m_dvr;
   logic     m_div_en, m_busy, m_ovr, m_valid;
   logic [7:0] m_out;

   always #5 clk = ~clk;

   ramp_phase_sequencer #(.DIV_LATENCY(L)) dut (
      .clk(clk), .rst(rst), .sample_tick(sample_tick), .note_period(note_period),
      .quotient(quotient), .div_en(div_en), .dividend(dividend), .divider(divider),
      .sample_out(sample_out), .sample_valid(sample_valid), .busy(busy), .overrun(overrun)
   );

   // stub divider: garbage right after start, dividend[7:0] once its latency has elapsed
   int q_cnt = 0;
   always @(posedge clk) begin
      if (div_en) begin
         q_cnt    <= 1;
         quotient <= 8'hA5;
      end else begin
         q_cnt <= q_cnt + 1;
         if (q_cnt == L - 1) quotient <= dividend[7:0];
      end
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      e_cnt = 0; a_edge = -1000;
      m_pos = 0; m_dvd = 0; m_dvr = 0; m_out = 8'd0;
      m_div_en = 1'b0; m_busy = 1'b0; m_ovr = 1'b0; m_valid = 1'b0;
   endtask

   // A request accepted at edge a: busy after edges a..a+L+1, capture at edge a+L+2.
   task automatic model_edge(input logic t, input int p);
      logic busy_before;
      e_cnt++;
      busy_before = (e_cnt - 1 >= a_edge) && (e_cnt - 1 <= a_edge + L + 1);
      m_valid = 1'b0; m_div_en = 1'b0; m_ovr = 1'b0;
      if (e_cnt == a_edge + L + 2) begin
         m_out   = m_dvd[7:0];
         m_valid = 1'b1;
         m_pos   = (m_dvd + 1 >= m_dvr) ? 0 : m_dvd + 1;
      end
      if (t) begin
         if (busy_before) begin
            m_ovr = 1'b1;
         end else if (p == 0) begin
            m_pos = 0; m_out = 8'd0; m_valid = 1'b1;
         end else begin
            m_dvr = p;
            if (m_pos >= p) m_pos = 0;
            m_dvd = m_pos;
            a_edge = e_cnt;
            m_div_en = 1'b1;
         end
      end
      m_busy = (e_cnt >= a_edge) && (e_cnt <= a_edge + L + 1);
   endtask

   task automatic compare();
      check("div_en", div_en, m_div_en);
      check("busy", busy, m_busy);
      check("overrun", overrun, m_ovr);
      check("sample_valid", sample_valid, m_valid);
      check("sample_out", sample_out, m_out);
      check("dividend", dividend, m_dvd);
      check("divider", divider, m_dvr);
   endtask

   task automatic step(input logic t, input logic [15:0] p);
      sample_tick = t;
      note_period = p;
      @(posedge clk);
      model_edge(t, int'(p));
      @(negedge clk);
      compare();
   endtask

   task automatic run_tick(input logic [15:0] p, input int gap, output int dvd, output int dvr,
                           output int out);
      step(1'b1, p);
      dvd = dividend;
      dvr = divider;
      out = -1;
      for (int i = 1; i < gap; i++) begin
         step(1'b0, p);
         if (sample_valid) out = sample_out;
      end
   endtask

   task automatic idle(input int n, input logic [15:0] p);
      for (int i = 0; i < n; i++) step(1'b0, p);
   endtask

   initial begin
      int ramp_exp[6] = '{0, 1, 2, 3, 0, 1};
      int period_tab[11] = '{0, 1, 2, 3, 4, 7, 9, 255, 256, 1000, 65535};
      int dvd, dvr, out, lat, n_en, n_val;
      logic [15:0] rp;

      rst = 1'b1; sample_tick = 1'b0; note_period = 16'd0;
      repeat (2) @(negedge clk);
      check("reset_div_en", div_en, 0);
      check("reset_busy", busy, 0);
      check("reset_valid", sample_valid, 0);
      check("reset_dividend", dividend, 0);
      rst = 1'b0;
      model_reset();
      idle(3, 16'd4);

      // ramp, period 4, ticks every 40 cycles
      for (int k = 0; k < 6; k++) begin
         step(1'b1, 16'd4);
         check("ramp_dividend", dividend, ramp_exp[k]);
         n_en = div_en;
         lat = -1;
         out = -1;
         for (int i = 1; i < 40; i++) begin
            step(1'b0, 16'd4);
            n_en += div_en;
            if (sample_valid && lat < 0) begin
               lat = i + 1;
               out = sample_out;
            end
         end
         check("ramp_latency", lat, 23);
         check("ramp_sample", out, ramp_exp[k]);
         check("ramp_div_en_count", n_en, 1);
      end

      // silent note
      step(1'b1, 16'd0);
      check("silent_valid", sample_valid, 1);
      check("silent_out", sample_out, 0);
      check("silent_no_div_en", div_en, 0);
      idle(3, 16'd4);
      run_tick(16'd4, 24, dvd, dvr, out);
      check("silent_pos_zero", dvd, 0);

      // overrun
      step(1'b1, 16'd0);
      idle(2, 16'd8);
      step(1'b1, 16'd8);
      idle(4, 16'd8);
      step(1'b1, 16'd8);
      check("overrun_pulse", overrun, 1);
      n_val = 0;
      for (int i = 0; i < 30; i++) begin
         step(1'b0, 16'd8);
         n_val += sample_valid;
      end
      check("overrun_one_valid", n_val, 1);
      run_tick(16'd8, 24, dvd, dvr, out);
      check("overrun_next_dividend", dvd, 1);

      // period shrink
      step(1'b1, 16'd0);
      idle(2, 16'd10);
      for (int k = 0; k < 7; k++) run_tick(16'd10, 24, dvd, dvr, out);
      run_tick(16'd5, 24, dvd, dvr, out);
      check("shrink_dividend", dvd, 0);
      check("shrink_divider", dvr, 5);
      run_tick(16'd5, 24, dvd, dvr, out);
      check("shrink_next_dividend", dvd, 1);

      // wide boundary: preload phase position near the top of the range
      dut.pos = 16'hFFFE;
      m_pos = 65534;
      run_tick(16'hFFFF, 24, dvd, dvr, out);
      check("wide_dividend", dvd, 65534);
      check("wide_sample", out, 254);
      run_tick(16'hFFFF, 24, dvd, dvr, out);
      check("wide_wrap", dvd, 0);

      // asynchronous reset in the middle of a wait
      step(1'b1, 16'd4);
      idle(8, 16'd4);
      #2 rst = 1'b1;
      #1;
      check("async_busy", busy, 0);
      check("async_dividend", dividend, 0);
      check("async_divider", divider, 0);
      check("async_sample_out", sample_out, 0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      idle(30, 16'd4);
      run_tick(16'd4, 24, dvd, dvr, out);
      check("post_reset_dividend", dvd, 0);

      // randomized ticks and period changes
      rp = 16'd4;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0) rp = 16'(period_tab[$urandom_range(0, 10)]);
         step(($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0, rp);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
